// File: rtl/ik_iter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ik_iter_ctrl
// Brief   : IK solver iteration sequencer (load, run core, check error, stop).
//           Optional cycle counter enabled by defining IK_ITER_PERF_EN.
// Revision: 1.0
// ============================================================================
module ik_iter_ctrl #(
   parameter int MAX_JOINT = 6,
   parameter int W         = 36,
   parameter int ITER_W    = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [ITER_W-1:0]          max_iter,
   input  logic [W-1:0]               tol,
   input  logic [MAX_JOINT*4*W-1:0]   dh_init,
   output logic                       core_rst,
   output logic                       core_en,
   output logic [MAX_JOINT*4*W-1:0]   core_dh_in,
   input  logic                       core_done,
   input  logic [MAX_JOINT*4*W-1:0]   core_dh_out,
   input  logic [6*W-1:0]             core_err,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 status,
   output logic [ITER_W-1:0]          iter_count,
   output logic [31:0]                cycle_count
);

   localparam int DH_W = MAX_JOINT*4*W;
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT-1);

   localparam logic [2:0] c_idle   = 3'd0;
   localparam logic [2:0] c_clear  = 3'd1;
   localparam logic [2:0] c_run    = 3'd2;
   localparam logic [2:0] c_check  = 3'd3;
   localparam logic [2:0] c_finish = 3'd4;

   localparam logic [1:0] c_st_none  = 2'b00;
   localparam logic [1:0] c_st_conv  = 2'b01;
   localparam logic [1:0] c_st_limit = 2'b10;
   localparam logic [1:0] c_st_abort = 2'b11;

   logic [2:0]        r_state;
   logic [DH_W-1:0]   r_dh;
   logic [ITER_W-1:0] r_max_iter;
   logic [W-1:0]      r_tol;
   logic [6*W-1:0]    r_err;
   logic [ITER_W-1:0] r_iter;
   logic [1:0]        r_status;
   logic [WD_W-1:0]   r_wdog;
   logic [W-1:0]      w_err_max;
   logic [W-1:0]      w_abs;

   // The most-negative code has no positive counterpart; clamp it to max positive.
   function automatic logic [W-1:0] abs_sat(input logic [W-1:0] v);
      if (v == {1'b1, {(W-1){1'b0}}})
         return {1'b0, {(W-1){1'b1}}};
      else if (v[W-1])
         return -v;
      else
         return v;
   endfunction

   always_comb begin
      w_err_max = '0;
      w_abs     = '0;
      for (int i = 0; i < 6; i++) begin
         w_abs = abs_sat(r_err[i*W +: W]);
         if (w_abs > w_err_max)
            w_err_max = w_abs;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_idle;
         r_dh       <= '0;
         r_max_iter <= '0;
         r_tol      <= '0;
         r_err      <= '0;
         r_iter     <= '0;
         r_status   <= c_st_none;
         r_wdog     <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (start) begin
                  r_dh       <= dh_init;
                  r_max_iter <= max_iter;
                  r_tol      <= tol;
                  r_iter     <= '0;
                  if (max_iter == '0) begin
                     r_status <= c_st_limit;
                     r_state  <= c_finish;
                  end else begin
                     r_status <= c_st_none;
                     r_state  <= c_clear;
                  end
               end
            end
            c_clear: begin
               r_wdog <= '0;
               if (abort) begin
                  r_status <= c_st_abort;
                  r_state  <= c_finish;
               end else begin
                  r_state <= c_run;
               end
            end
            c_run: begin
               // Abort outranks a coincident core result and the watchdog.
               if (abort) begin
                  r_status <= c_st_abort;
                  r_state  <= c_finish;
               end else if (core_done) begin
                  r_dh    <= core_dh_out;
                  r_err   <= core_err;
                  r_iter  <= r_iter + 1'b1;
                  r_state <= c_check;
               end else if (r_wdog == c_wd_last) begin
                  r_status <= c_st_abort;
                  r_state  <= c_finish;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            c_check: begin
               if (abort) begin
                  r_status <= c_st_abort;
                  r_state  <= c_finish;
               end else if (w_err_max <= r_tol) begin
                  r_status <= c_st_conv;
                  r_state  <= c_finish;
               end else if (r_iter == r_max_iter) begin
                  r_status <= c_st_limit;
                  r_state  <= c_finish;
               end else begin
                  r_state <= c_clear;
               end
            end
            c_finish: r_state <= c_idle;
            default:  r_state <= c_idle;
         endcase
      end
   end

   assign core_rst   = reset | (r_state == c_clear);
   assign core_en    = (r_state == c_run);
   assign core_dh_in = r_dh;
   assign busy       = (r_state != c_idle);
   assign done       = (r_state == c_finish);
   assign status     = r_status;
   assign iter_count = r_iter;

`ifdef IK_ITER_PERF_EN
   logic [31:0] r_cycles;

   // Counts every busy cycle including FINISH; holds while idle.
   always_ff @(posedge clk) begin
      if (reset)
         r_cycles <= '0;
      else if ((r_state == c_idle) && start)
         r_cycles <= '0;
      else if (r_state != c_idle)
         r_cycles <= r_cycles + 32'd1;
   end

   assign cycle_count = r_cycles;
`else
   assign cycle_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/ik_iter_ctrl.md
# ik_iter_ctrl

Iteration sequencer for the IK solver core. It loads the initial DH parameters and runs the core one Jacobian-update iteration at a time. After each iteration it feeds the updated parameters back into the core and checks the end-effector error against a tolerance. It stops on convergence, iteration limit, per-iteration timeout or host abort. It sits between the Avalon register file, which supplies start, tolerance, limit and initial parameters, and the `ik_swift` core.

## Interface
Parameters:
- `MAX_JOINT`, 6 — number of joints.
- `W`, 36 — fixed-point word width (Q20.16, two's complement).
- `ITER_W`, 16 — iteration counter width.
- `TIMEOUT`, 4096 — maximum cycles allowed per core iteration.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — reset, synchronous, active-high.
- `start` in 1 — begin a solve; sampled only in IDLE.
- `abort` in 1 — terminate the solve in progress; ignored in IDLE.
- `max_iter` in ITER_W — iteration limit; sampled at start.
- `tol` in W — unsigned error tolerance; sampled at start.
- `dh_init` in MAX_JOINT*4*W — initial DH parameters, per joint {theta, offset, distance, alpha}.
- `core_rst` out 1 — core reset.
- `core_en` out 1 — core enable.
- `core_dh_in` out MAX_JOINT*4*W — parameters driven to the core; equals the internal parameter register.
- `core_done` in 1 — single-cycle pulse from the core: an iteration result is valid.
- `core_dh_out` in MAX_JOINT*4*W — updated parameters from the core.
- `core_err` in 6*W — signed pose error {x, y, z, rx, ry, rz}.
- `busy` out 1 — a solve is in progress.
- `done` out 1 — single-cycle completion pulse.
- `status` out 2 — 00 none, 01 converged, 10 iteration limit, 11 timeout/abort.
- `iter_count` out ITER_W — iterations completed in the current or last solve.
- `cycle_count` out 32 — see Configuration.

## Operation
- States are IDLE, CLEAR, RUN, CHECK and FINISH.
- IDLE, `start`=1:
  - Latch `dh_init` into the parameter register.
  - Latch `max_iter` and `tol`.
  - Set `iter_count`=0 and `status`=00.
  - If `max_iter`==0, go to FINISH with `status`=10 and do not run the core. Otherwise go to CLEAR.
- CLEAR: `core_rst`=1 and `core_en`=0 for exactly one cycle, then RUN.
- RUN: `core_en`=1, and the watchdog counts from 0.
  - On `core_done`: latch `core_dh_out` into the parameter register, register `core_err`, increment `iter_count`, go to CHECK.
  - If the watchdog reaches TIMEOUT-1 without `core_done`: `status`=11, go to FINISH.
- CHECK: compute e = max over i of |err_i|, using the registered error.
  - |x| of the most-negative value saturates to 2^(W-1)-1.
  - If e <= `tol`: `status`=01, FINISH.
  - Else if `iter_count`==`max_iter`: `status`=10, FINISH.
  - Else: CLEAR.
- FINISH: `done`=1 for one cycle, then IDLE. `status`, `iter_count` and the parameter register hold until the next accepted start.
- `abort` in CLEAR, RUN or CHECK: next state is FINISH with `status`=11, and `core_en` drops in the following cycle.
- Simultaneous events:
  - `abort` and `core_done` in the same RUN cycle: abort wins. Parameters are not updated and `iter_count` is not incremented.
  - `start` while `busy` is ignored. `abort` in FINISH is ignored.
- `busy` = 1 in every state except IDLE.
- Parameter register update: whole-vector only, never partial.
- Tolerance comparison: unsigned, W bits.

## Timing
- Reset values:
  - Outputs: `busy` 0, `done` 0, `status` 00, `iter_count` 0, `cycle_count` 0, `core_en` 0.
  - `core_dh_in` all zero; state IDLE.
  - `core_rst` = `reset` OR (state==CLEAR), so the core is held in reset while `reset` is high.
- Start accepted at cycle 0:
  - Cycle 1: CLEAR, `core_rst`=1.
  - Cycle 2: RUN, `core_en`=1.
- `core_done` at cycle N:
  - Cycle N+1: CHECK.
  - Cycle N+2: CLEAR (next iteration) or FINISH with `done`=1.
  - Cycle N+3: `busy` falls to 0.
- Per-iteration overhead beyond core latency: 3 cycles (CHECK, CLEAR, first RUN cycle).
- `max_iter`==0: FINISH at cycle 1, `busy` low at cycle 2.
- Timeout: FINISH follows exactly TIMEOUT RUN cycles without `core_done`.
- Reset asserted mid-solve: next cycle is IDLE with all reset values; no `done` pulse.

## Configuration
- `IK_ITER_PERF_EN` defined:
  - `cycle_count` clears at an accepted start and increments every cycle while `busy`.
  - It freezes in FINISH, holding the total solve latency (FINISH cycle included), until the next start.
- `IK_ITER_PERF_EN` undefined: `cycle_count` is tied to 0 and no counter logic is present.

## Test plan
- Convergence: `tol`=0x00000_0100 and `max_iter`=10; core model returns max |err| of 0x1000, 0x400, 0x80 on iterations 1-3. Required: `status`=01, `iter_count`=3, one `done` pulse, `core_dh_in` equal to the third `core_dh_out`.
- Limit: `tol`=0 and `max_iter`=4, with nonzero error every iteration. Required: exactly 4 CLEAR pulses on `core_rst`, `status`=10, `iter_count`=4.
- Timeout: TIMEOUT=16 and the core never pulses `core_done`. Required: `done` 16 cycles after RUN entry, `status`=11, `iter_count`=0.
- Abort race: `abort` and `core_done` in the same RUN cycle on iteration 2. Required: `status`=11, `iter_count`=1, parameters from iteration 1 retained.
- Edge: `max_iter`=0. Required: `done` at cycle 1, `status`=10, `core_en` never high. Also: `core_err` x=0x8_0000_0000 with `tol`=0x7_FFFF_FFFF. Required: converged (saturated |x| equals `tol`).
- With `IK_ITER_PERF_EN` and a 10-cycle core latency over 2 iterations: `cycle_count`=27. Reset pulsed mid-RUN returns all outputs to reset values with no `done`.
